siso_shift_ctrl: RTL

Controller that sequences a serial-in/serial-out shift datapath. It accepts parallel words through a valid/ready handshake and serialises each word onto a single-bit output, one bit per clock, with a bit counter and frame FSM. It enforces a configurable inter-frame gap and counts completed frames. It sits between a parallel producer and the serial D-flip-flop chain it drives.

---
 rtl/siso_shift_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl: serialises parallel words onto a single-bit output.
// Words are accepted through a valid/ready handshake. The bit order is
// chosen per word. A fixed idle gap follows each frame, and completed
// frames are counted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for in_valid; in_ready high
// S_SHIFT | presenting frame bits on sout, one per clock
// S_GAP   | inter-frame idle gap running, no accept
module siso_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BC_W  = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

  localparam logic [BC_W-1:0]  CNT_LAST = BC_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic             HAS_GAP  = (GAP > 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               msb_q, msb_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               sout_q, sout_d;
  logic               sout_valid_q, sout_valid_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  // Next-state and registered-output decode. The shift register is kept
  // pre-shifted so that the next bit always sits at its outgoing end.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    msb_d        = msb_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          msb_d        = msb_first;
          shreg_d      = msb_first ? (in_data << 1) : (in_data >> 1);
          sout_d       = msb_first ? in_data[WIDTH-1] : in_data[0];
          sout_valid_d = 1'b1;
          bit_cnt_d    = BC_W'(1);
          state_d      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == CNT_LAST) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
          bit_cnt_d   = '0;
          if (HAS_GAP) begin
            gap_cnt_d = GAP_INIT;
            state_d   = S_GAP;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          sout_d       = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
          shreg_d      = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
          sout_valid_d = 1'b1;
          bit_cnt_d    = bit_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      msb_q        <= 1'b0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      msb_q        <= msb_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
